// File: rtl/adma_pkg.sv
// Shared types and width helpers for the ADMA transaction issue path.
package adma_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } issue_state_e;

  function automatic int os_cnt_w(input int max_os);
    return $clog2(max_os + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/adma_chn_id_fifo.sv
// In-order channel-ID FIFO; pop on empty is ignored, push on full only lands with a same-cycle pop.
module adma_chn_id_fifo
  import adma_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2,
  parameter int CNT_W = os_cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = ptr_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign count = cnt_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/adma_as_atx_issue.sv
// Issues one granted AR+AW transaction pair and tracks per-direction outstanding channel IDs.
// Optional ADMA_ATX_ISSUE_STALL_CNT_EN adds saturating AR/AW stall counters.
//   state | meaning
//   IDLE  | waiting for a transaction, atx_rdy when both directions have a free slot
//   ISSUE | AR and/or AW valid still pending a handshake
module adma_as_atx_issue
  import adma_pkg::*;
#(
  parameter int DMA_CHN_NUM   = 4,
  parameter int SRC_ADDR_W    = 32,
  parameter int DST_ADDR_W    = 32,
  parameter int MST_ID_W      = 5,
  parameter int ATX_LEN_W     = 8,
  parameter int MAX_OS        = 4,
  parameter int DMA_CHN_NUM_W = $clog2(DMA_CHN_NUM),
  parameter int OS_CNT_W      = os_cnt_w(MAX_OS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DMA_CHN_NUM_W-1:0] atx_chn_id,
  input  logic [MST_ID_W-1:0]      atx_arid,
  input  logic [SRC_ADDR_W-1:0]    atx_araddr,
  input  logic [ATX_LEN_W-1:0]     atx_arlen,
  input  logic [1:0]               atx_arburst,
  input  logic [MST_ID_W-1:0]      atx_awid,
  input  logic [DST_ADDR_W-1:0]    atx_awaddr,
  input  logic [ATX_LEN_W-1:0]     atx_awlen,
  input  logic [1:0]               atx_awburst,
  input  logic                     atx_vld,
  output logic                     atx_rdy,
  output logic [MST_ID_W-1:0]      m_arid,
  output logic [SRC_ADDR_W-1:0]    m_araddr,
  output logic [ATX_LEN_W-1:0]     m_arlen,
  output logic [1:0]               m_arburst,
  output logic                     m_arvalid,
  input  logic                     m_arready,
  output logic [MST_ID_W-1:0]      m_awid,
  output logic [DST_ADDR_W-1:0]    m_awaddr,
  output logic [ATX_LEN_W-1:0]     m_awlen,
  output logic [1:0]               m_awburst,
  output logic                     m_awvalid,
  input  logic                     m_awready,
  input  logic                     rd_done,
  input  logic                     wr_done,
  output logic                     rd_cmpl_vld,
  output logic [DMA_CHN_NUM_W-1:0] rd_cmpl_chn_id,
  output logic                     wr_cmpl_vld,
  output logic [DMA_CHN_NUM_W-1:0] wr_cmpl_chn_id,
  output logic [OS_CNT_W-1:0]      ar_os_cnt,
  output logic [OS_CNT_W-1:0]      aw_os_cnt,
  output logic                     os_err
`ifdef ADMA_ATX_ISSUE_STALL_CNT_EN
  ,
  output logic [31:0]              ar_stall_cnt,
  output logic [31:0]              aw_stall_cnt
`endif
);

  issue_state_e state_q, state_d;
  logic arvalid_q, arvalid_d, awvalid_q, awvalid_d;
  logic [MST_ID_W-1:0]      arid_q, arid_d, awid_q, awid_d;
  logic [SRC_ADDR_W-1:0]    araddr_q, araddr_d;
  logic [DST_ADDR_W-1:0]    awaddr_q, awaddr_d;
  logic [ATX_LEN_W-1:0]     arlen_q, arlen_d, awlen_q, awlen_d;
  logic [1:0]               arburst_q, arburst_d, awburst_q, awburst_d;
  logic [DMA_CHN_NUM_W-1:0] chn_id_q, chn_id_d;
  logic rd_cmpl_vld_q, rd_cmpl_vld_d, wr_cmpl_vld_q, wr_cmpl_vld_d;
  logic [DMA_CHN_NUM_W-1:0] rd_cmpl_chn_q, rd_cmpl_chn_d, wr_cmpl_chn_q, wr_cmpl_chn_d;
  logic os_err_q, os_err_d;

  logic ar_hs, aw_hs, rdy_int;
  logic rd_empty, rd_full, wr_empty, wr_full;
  logic [DMA_CHN_NUM_W-1:0] rd_head, wr_head;

  adma_chn_id_fifo #(.DEPTH(MAX_OS), .WIDTH(DMA_CHN_NUM_W), .CNT_W(OS_CNT_W)) u_rd_fifo (
    .clk(clk), .rst_n(rst_n), .push(ar_hs), .push_data(chn_id_q), .pop(rd_done),
    .head(rd_head), .count(ar_os_cnt), .empty(rd_empty), .full(rd_full)
  );

  adma_chn_id_fifo #(.DEPTH(MAX_OS), .WIDTH(DMA_CHN_NUM_W), .CNT_W(OS_CNT_W)) u_wr_fifo (
    .clk(clk), .rst_n(rst_n), .push(aw_hs), .push_data(chn_id_q), .pop(wr_done),
    .head(wr_head), .count(aw_os_cnt), .empty(wr_empty), .full(wr_full)
  );

  assign ar_hs   = arvalid_q & m_arready;
  assign aw_hs   = awvalid_q & m_awready;
  assign rdy_int = (state_q == IDLE) & ~rd_full & ~wr_full;

  always_comb begin
    state_d   = state_q;
    arvalid_d = arvalid_q & ~ar_hs;
    awvalid_d = awvalid_q & ~aw_hs;
    arid_d    = arid_q;    araddr_d = araddr_q; arlen_d = arlen_q; arburst_d = arburst_q;
    awid_d    = awid_q;    awaddr_d = awaddr_q; awlen_d = awlen_q; awburst_d = awburst_q;
    chn_id_d  = chn_id_q;
    case (state_q)
      IDLE: begin
        if (atx_vld && rdy_int) begin
          arid_d    = atx_arid;  araddr_d = atx_araddr; arlen_d = atx_arlen; arburst_d = atx_arburst;
          awid_d    = atx_awid;  awaddr_d = atx_awaddr; awlen_d = atx_awlen; awburst_d = atx_awburst;
          chn_id_d  = atx_chn_id;
          arvalid_d = 1'b1;
          awvalid_d = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: if (!arvalid_d && !awvalid_d) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Completions report the FIFO head popped this cycle; an empty pop only flags the error.
    rd_cmpl_vld_d = rd_done & ~rd_empty;
    wr_cmpl_vld_d = wr_done & ~wr_empty;
    rd_cmpl_chn_d = rd_cmpl_vld_d ? rd_head : rd_cmpl_chn_q;
    wr_cmpl_chn_d = wr_cmpl_vld_d ? wr_head : wr_cmpl_chn_q;
    os_err_d      = os_err_q | (rd_done & rd_empty) | (wr_done & wr_empty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      arvalid_q <= 1'b0; awvalid_q <= 1'b0;
      arid_q    <= '0;   araddr_q  <= '0; arlen_q <= '0; arburst_q <= '0;
      awid_q    <= '0;   awaddr_q  <= '0; awlen_q <= '0; awburst_q <= '0;
      chn_id_q  <= '0;
      rd_cmpl_vld_q <= 1'b0; rd_cmpl_chn_q <= '0;
      wr_cmpl_vld_q <= 1'b0; wr_cmpl_chn_q <= '0;
      os_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      arvalid_q <= arvalid_d; awvalid_q <= awvalid_d;
      arid_q    <= arid_d;    araddr_q  <= araddr_d; arlen_q <= arlen_d; arburst_q <= arburst_d;
      awid_q    <= awid_d;    awaddr_q  <= awaddr_d; awlen_q <= awlen_d; awburst_q <= awburst_d;
      chn_id_q  <= chn_id_d;
      rd_cmpl_vld_q <= rd_cmpl_vld_d; rd_cmpl_chn_q <= rd_cmpl_chn_d;
      wr_cmpl_vld_q <= wr_cmpl_vld_d; wr_cmpl_chn_q <= wr_cmpl_chn_d;
      os_err_q  <= os_err_d;
    end
  end

  assign atx_rdy        = rdy_int;
  assign m_arvalid      = arvalid_q;
  assign m_arid         = arid_q;
  assign m_araddr       = araddr_q;
  assign m_arlen        = arlen_q;
  assign m_arburst      = arburst_q;
  assign m_awvalid      = awvalid_q;
  assign m_awid         = awid_q;
  assign m_awaddr       = awaddr_q;
  assign m_awlen        = awlen_q;
  assign m_awburst      = awburst_q;
  assign rd_cmpl_vld    = rd_cmpl_vld_q;
  assign rd_cmpl_chn_id = rd_cmpl_chn_q;
  assign wr_cmpl_vld    = wr_cmpl_vld_q;
  assign wr_cmpl_chn_id = wr_cmpl_chn_q;
  assign os_err         = os_err_q;

`ifdef ADMA_ATX_ISSUE_STALL_CNT_EN
  logic [31:0] ar_stall_q, ar_stall_d, aw_stall_q, aw_stall_d;

  always_comb begin
    ar_stall_d = ar_stall_q;
    aw_stall_d = aw_stall_q;
    if (arvalid_q && !m_arready && !(&ar_stall_q)) ar_stall_d = ar_stall_q + 32'd1;
    if (awvalid_q && !m_awready && !(&aw_stall_q)) aw_stall_d = aw_stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_stall_q <= '0;
      aw_stall_q <= '0;
    end else begin
      ar_stall_q <= ar_stall_d;
      aw_stall_q <= aw_stall_d;
    end
  end

  assign ar_stall_cnt = ar_stall_q;
  assign aw_stall_cnt = aw_stall_q;
`endif

endmodule

// File: tb/tb_adma_as_atx_issue.sv
// Scoreboard bench for adma_as_atx_issue: payload and completion expectations queued at accept.
module tb_adma_as_atx_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  atx_chn_id;
  logic [4:0]  atx_arid, atx_awid;
  logic [31:0] atx_araddr, atx_awaddr;
  logic [7:0]  atx_arlen, atx_awlen;
  logic [1:0]  atx_arburst, atx_awburst;
  logic        atx_vld, atx_rdy;
  logic [4:0]  m_arid, m_awid;
  logic [31:0] m_araddr, m_awaddr;
  logic [7:0]  m_arlen, m_awlen;
  logic [1:0]  m_arburst, m_awburst;
  logic        m_arvalid, m_arready, m_awvalid, m_awready;
  logic        rd_done, wr_done;
  logic        rd_cmpl_vld, wr_cmpl_vld;
  logic [1:0]  rd_cmpl_chn_id, wr_cmpl_chn_id;
  logic [2:0]  ar_os_cnt, aw_os_cnt;
  logic        os_err;
`ifdef ADMA_ATX_ISSUE_STALL_CNT_EN
  logic [31:0] ar_stall_cnt, aw_stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  logic [46:0] ar_exp_q[$];
  logic [46:0] aw_exp_q[$];
  logic [1:0]  rd_exp_q[$];
  logic [1:0]  wr_exp_q[$];

  always #5 clk = ~clk;

  adma_as_atx_issue dut (
    .clk(clk), .rst_n(rst_n),
    .atx_chn_id(atx_chn_id),
    .atx_arid(atx_arid), .atx_araddr(atx_araddr), .atx_arlen(atx_arlen), .atx_arburst(atx_arburst),
    .atx_awid(atx_awid), .atx_awaddr(atx_awaddr), .atx_awlen(atx_awlen), .atx_awburst(atx_awburst),
    .atx_vld(atx_vld), .atx_rdy(atx_rdy),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awburst(m_awburst),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .rd_done(rd_done), .wr_done(wr_done),
    .rd_cmpl_vld(rd_cmpl_vld), .rd_cmpl_chn_id(rd_cmpl_chn_id),
    .wr_cmpl_vld(wr_cmpl_vld), .wr_cmpl_chn_id(wr_cmpl_chn_id),
    .ar_os_cnt(ar_os_cnt), .aw_os_cnt(aw_os_cnt), .os_err(os_err)
`ifdef ADMA_ATX_ISSUE_STALL_CNT_EN
    , .ar_stall_cnt(ar_stall_cnt), .aw_stall_cnt(aw_stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: payloads on handshakes, channel IDs on completion pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_arvalid && m_arready) begin
        if (ar_exp_q.size() == 0) chk("ar_unexpected", 1, 0);
        else chk("ar_payload", {m_arid, m_araddr, m_arlen, m_arburst}, ar_exp_q.pop_front());
      end
      if (m_awvalid && m_awready) begin
        if (aw_exp_q.size() == 0) chk("aw_unexpected", 1, 0);
        else chk("aw_payload", {m_awid, m_awaddr, m_awlen, m_awburst}, aw_exp_q.pop_front());
      end
      if (rd_cmpl_vld) begin
        if (rd_exp_q.size() == 0) chk("rd_cmpl_unexpected", 1, 0);
        else chk("rd_cmpl_chn", rd_cmpl_chn_id, rd_exp_q.pop_front());
      end
      if (wr_cmpl_vld) begin
        if (wr_exp_q.size() == 0) chk("wr_cmpl_unexpected", 1, 0);
        else chk("wr_cmpl_chn", wr_cmpl_chn_id, wr_exp_q.pop_front());
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input int chn, input logic [31:0] ara, input logic [31:0] awa, input logic [7:0] len);
    int n = 0;
    while (!atx_rdy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      chk("send_timeout", 1, 0);
      return;
    end
    atx_chn_id  = 2'(chn);
    atx_arid    = 5'(chn + 1);  atx_araddr = ara; atx_arlen = len; atx_arburst = 2'd1;
    atx_awid    = 5'(chn + 9);  atx_awaddr = awa; atx_awlen = len; atx_awburst = 2'd1;
    atx_vld     = 1'b1;
    @(posedge clk);
    ar_exp_q.push_back({5'(chn + 1), ara, len, 2'd1});
    aw_exp_q.push_back({5'(chn + 9), awa, len, 2'd1});
    rd_exp_q.push_back(2'(chn));
    wr_exp_q.push_back(2'(chn));
    #1 atx_vld = 1'b0;
  endtask

  task automatic pulse_rd();
    rd_done = 1'b1;
    @(posedge clk); #1 rd_done = 1'b0;
  endtask

  task automatic pulse_wr();
    wr_done = 1'b1;
    @(posedge clk); #1 wr_done = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    atx_chn_id = '0; atx_arid = '0; atx_araddr = '0; atx_arlen = '0; atx_arburst = '0;
    atx_awid = '0; atx_awaddr = '0; atx_awlen = '0; atx_awburst = '0;
    atx_vld = 1'b0; m_arready = 1'b1; m_awready = 1'b1; rd_done = 1'b0; wr_done = 1'b0;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    chk("rst_atx_rdy", atx_rdy, 1);
    chk("rst_arvalid", m_arvalid, 0);
    chk("rst_awvalid", m_awvalid, 0);
    chk("rst_cnts", {ar_os_cnt, aw_os_cnt}, 0);
    chk("rst_os_err", os_err, 0);

    // single transaction
    send(2, 32'h1000, 32'h2000, 8'd7);
    chk("single_valids", {m_arvalid, m_awvalid}, 2'b11);
    chk("single_rdy_issue", atx_rdy, 0);
    @(posedge clk); #1;
    chk("single_cnts", {ar_os_cnt, aw_os_cnt}, {3'd1, 3'd1});
    chk("single_valids_drop", {m_arvalid, m_awvalid}, 2'b00);
    chk("single_rdy_back", atx_rdy, 1);
    pulse_rd();
    chk("single_rd_cmpl", {rd_cmpl_vld, rd_cmpl_chn_id}, {1'b1, 2'd2});
    chk("single_ar_cnt0", ar_os_cnt, 0);
    pulse_wr();
    chk("single_wr_cmpl", {wr_cmpl_vld, wr_cmpl_chn_id}, {1'b1, 2'd2});
    @(posedge clk); #1;
    chk("single_cmpl_pulse", {rd_cmpl_vld, wr_cmpl_vld}, 2'b00);

    // skewed ready
    m_awready = 1'b0;
    send(1, 32'h3000, 32'h4440, 8'd3);
    for (int i = 0; i < 5; i++) begin
      chk("skew_awvalid", m_awvalid, 1);
      chk("skew_awaddr", m_awaddr, 32'h4440);
      chk("skew_rdy", atx_rdy, 0);
      if (i > 0) chk("skew_arvalid", m_arvalid, 0);
      @(posedge clk); #1;
    end
    m_awready = 1'b1;
    chk("skew_rdy_hs_cycle", atx_rdy, 0);
    @(posedge clk); #1;
    chk("skew_rdy_after", atx_rdy, 1);
    chk("skew_aw_cnt", aw_os_cnt, 1);
    pulse_rd();
    pulse_wr();

    // outstanding limit
    for (int c = 0; c < 4; c++) send(c, 32'h100 * (c + 1), 32'h8000 + 32'h40 * c, 8'(c));
    @(posedge clk); #1;
    chk("full_cnts", {ar_os_cnt, aw_os_cnt}, {3'd4, 3'd4});
    chk("full_rdy", atx_rdy, 0);
    pulse_wr();
    chk("full_wr_cmpl0", wr_cmpl_chn_id, 0);
    chk("full_aw_cnt3", aw_os_cnt, 3);
    chk("full_rdy_ar_full", atx_rdy, 0);
    pulse_rd();
    chk("full_rdy_free", atx_rdy, 1);

    // push and pop in the same cycle
    m_awready = 1'b0;
    send(0, 32'hA000, 32'hB000, 8'd15);
    @(posedge clk); #1;
    chk("pp_cnts", {ar_os_cnt, aw_os_cnt}, {3'd4, 3'd3});
    m_awready = 1'b1;
    wr_done   = 1'b1;
    @(posedge clk); #1 wr_done = 1'b0;
    chk("pp_aw_cnt", aw_os_cnt, 3);
    chk("pp_wr_cmpl", {wr_cmpl_vld, wr_cmpl_chn_id}, {1'b1, 2'd1});
    repeat (4) pulse_rd();
    repeat (3) pulse_wr();
    @(posedge clk); #1;
    chk("pp_drained", {ar_os_cnt, aw_os_cnt}, 0);

    // pop on empty
    pulse_rd();
    chk("err_set", os_err, 1);
    chk("err_cnt", ar_os_cnt, 0);
    @(posedge clk); #1;
    chk("err_sticky", os_err, 1);

    // reset mid-ISSUE
    m_arready = 1'b0;
    m_awready = 1'b0;
    send(3, 32'hC000, 32'hD000, 8'd1);
    chk("mid_valids", {m_arvalid, m_awvalid}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_valids", {m_arvalid, m_awvalid}, 2'b00);
    chk("rst_async_payload", {m_araddr, m_awaddr}, 0);
    chk("rst_async_err", os_err, 0);
    chk("rst_async_rdy", atx_rdy, 1);
    ar_exp_q.delete(); aw_exp_q.delete(); rd_exp_q.delete(); wr_exp_q.delete();
    m_arready = 1'b1;
    m_awready = 1'b1;
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef ADMA_ATX_ISSUE_STALL_CNT_EN
    m_arready = 1'b0;
    send(1, 32'hE000, 32'hF000, 8'd2);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("stall_ar", ar_stall_cnt, 3);
    chk("stall_aw", aw_stall_cnt, 0);
    m_arready = 1'b1;
    @(posedge clk); #1;
    pulse_rd();
    pulse_wr();
`endif

    @(posedge clk); #1;
    chk("sb_empty", {32'(ar_exp_q.size() + aw_exp_q.size()), 32'(rd_exp_q.size() + wr_exp_q.size())}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
